// File: rtl/tribus4_ctrl.sv
// Four-requester arbiter for the mirrored four-bank 128x8 memory datapath.
// Define TRIBUS4_CTRL_FIXED_PRIO_EN for fixed priority (requester 0 highest) instead of round-robin.
module tribus4_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req_i,
    input  logic [3:0] we_i,
    input  logic [6:0] addr0_i,
    input  logic [6:0] addr1_i,
    input  logic [6:0] addr2_i,
    input  logic [6:0] addr3_i,
    input  logic [7:0] wdata0_i,
    input  logic [7:0] wdata1_i,
    input  logic [7:0] wdata2_i,
    input  logic [7:0] wdata3_i,
    output logic [3:0] ack_o,
    output logic [7:0] rdata_o,
    output logic [6:0] bus_in0_o,
    output logic [6:0] bus_in1_o,
    output logic [6:0] bus_in2_o,
    output logic [6:0] bus_in3_o,
    output logic [7:0] bus_wdata_o,
    output logic [2:0] bus_ena_o,
    input  logic [7:0] bus_dout_i,
    output logic [1:0] o_dbg_state
);

    // Handshake: a requester raises req_i[k] with we/addr/wdata and holds them
    // stable until ack_o[k] pulses for one cycle; it drops req_i[k] the next cycle.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDATA  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t     r_state;
    logic [1:0] r_win;
    logic       r_we;
    logic [6:0] r_bus_in [4];

    logic [1:0] w_win;
    logic [6:0] w_addr;
    logic [7:0] w_wdata;

`ifdef TRIBUS4_CTRL_FIXED_PRIO_EN
    always_comb begin
        w_win = 2'd0;
        if (req_i[0])      w_win = 2'd0;
        else if (req_i[1]) w_win = 2'd1;
        else if (req_i[2]) w_win = 2'd2;
        else if (req_i[3]) w_win = 2'd3;
    end
`else
    logic [1:0] r_ptr;

    // Scan downward so the candidate nearest to (pointer + 1) is assigned last and wins.
    always_comb begin
        logic [1:0] v_idx;
        w_win = 2'd0;
        v_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            v_idx = r_ptr + 2'(i + 1);
            if (req_i[v_idx]) w_win = v_idx;
        end
    end
`endif

    always_comb begin
        w_addr  = addr0_i;
        w_wdata = wdata0_i;
        case (w_win)
            2'd0: begin w_addr = addr0_i; w_wdata = wdata0_i; end
            2'd1: begin w_addr = addr1_i; w_wdata = wdata1_i; end
            2'd2: begin w_addr = addr2_i; w_wdata = wdata2_i; end
            default: begin w_addr = addr3_i; w_wdata = wdata3_i; end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_win       <= 2'd0;
            r_we        <= 1'b0;
            ack_o       <= 4'b0000;
            rdata_o     <= 8'h00;
            bus_wdata_o <= 8'h00;
            bus_ena_o   <= 3'b000;
            for (int i = 0; i < 4; i++) r_bus_in[i] <= 7'd0;
`ifndef TRIBUS4_CTRL_FIXED_PRIO_EN
            r_ptr       <= 2'd3;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (|req_i) begin
                        r_win     <= w_win;
                        r_we      <= we_i[w_win];
                        bus_ena_o <= {we_i[w_win], w_win};
                        // Writes go to every bank so the banks stay mirrored copies.
                        if (we_i[w_win]) begin
                            for (int i = 0; i < 4; i++) r_bus_in[i] <= w_addr;
                            bus_wdata_o <= w_wdata;
                        end else begin
                            r_bus_in[w_win] <= w_addr;
                        end
                        r_state <= ACCESS;
                    end
                end
                ACCESS: begin
                    bus_ena_o <= {1'b0, r_win};
                    if (r_we) begin
                        ack_o   <= 4'b0001 << r_win;
                        r_state <= DONE;
                    end else begin
                        r_state <= RDATA;
                    end
                end
                RDATA: begin
                    rdata_o <= bus_dout_i;
                    ack_o   <= 4'b0001 << r_win;
                    r_state <= DONE;
                end
                default: begin
                    ack_o   <= 4'b0000;
`ifndef TRIBUS4_CTRL_FIXED_PRIO_EN
                    r_ptr   <= r_win;
`endif
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus_in0_o   = r_bus_in[0];
    assign bus_in1_o   = r_bus_in[1];
    assign bus_in2_o   = r_bus_in[2];
    assign bus_in3_o   = r_bus_in[3];
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_tribus4_ctrl.sv
// Directed bench for tribus4_ctrl with a four-bank mirrored memory model on the bus side.
module tb_tribus4_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] we;
  logic [6:0] addr [4];
  logic [7:0] wdata [4];
  logic [3:0] ack;
  logic [7:0] rdata;
  logic [6:0] bin [4];
  logic [7:0] bus_wdata;
  logic [2:0] bus_ena;
  logic [7:0] bus_dout;
  logic [1:0] dbg_state;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  logic [7:0] mem [4][128];
  bit         mem_init = 1'b0;

  always #5 clk = ~clk;

  tribus4_ctrl dut (
    .clk(clk), .rst(rst), .req_i(req), .we_i(we),
    .addr0_i(addr[0]), .addr1_i(addr[1]), .addr2_i(addr[2]), .addr3_i(addr[3]),
    .wdata0_i(wdata[0]), .wdata1_i(wdata[1]), .wdata2_i(wdata[2]), .wdata3_i(wdata[3]),
    .ack_o(ack), .rdata_o(rdata),
    .bus_in0_o(bin[0]), .bus_in1_o(bin[1]), .bus_in2_o(bin[2]), .bus_in3_o(bin[3]),
    .bus_wdata_o(bus_wdata), .bus_ena_o(bus_ena), .bus_dout_i(bus_dout),
    .o_dbg_state(dbg_state)
  );

  // Datapath model: broadcast write strobe, read muxed from the selected bank.
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int b = 0; b < 4; b++)
        for (int a = 0; a < 128; a++) mem[b][a] <= 8'h00;
      mem_init <= 1'b1;
    end else if (bus_ena[2]) begin
      for (int b = 0; b < 4; b++) mem[b][bin[b]] <= bus_wdata;
    end
  end

  assign bus_dout = mem[bus_ena[1:0]][bin[bus_ena[1:0]]];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int k, input logic w, input logic [6:0] a, input logic [7:0] d);
    we[k]    = w;
    addr[k]  = a;
    wdata[k] = d;
    req[k]   = 1'b1;
  endtask

  // One uncontended access; exp_rd is the read value, or the held rdata for a write.
  task automatic access(input int k, input logic w, input logic [6:0] a, input logic [7:0] d,
                        input logic [7:0] exp_rd, input string tag);
    logic [3:0] oh;
    oh = 4'b0001 << k;
    set_req(k, w, a, d);
    repeat (w ? 2 : 3) tick();
    chk({tag, "_ack"}, ack, oh);
    chk({tag, "_rdata"}, rdata, exp_rd);
    req[k] = 1'b0;
    tick();
    chk({tag, "_ack_clr"}, ack, 4'b0000);
    chk({tag, "_idle"}, dbg_state, 2'd0);
  endtask

  initial begin
    int first;
    int second;
    rst = 1'b1;
    req = 4'b0000;
    we  = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      addr[i]  = 7'd0;
      wdata[i] = 8'h00;
    end
    tick();
    tick();
    rst = 1'b0;
    tick();

    chk("rst_ena", bus_ena, 3'b000);
    chk("rst_ack", ack, 4'b0000);
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_bin0", bin[0], 7'd0);
    chk("rst_wdata", bus_wdata, 8'h00);
    chk("rst_state", dbg_state, 2'd0);

    // Requester 2 writes 0x5A to 0x11.
    set_req(2, 1'b1, 7'h11, 8'h5A);
    tick();
    chk("wr_ena", bus_ena, 3'b110);
    for (int i = 0; i < 4; i++) chk($sformatf("wr_bin%0d", i), bin[i], 7'h11);
    chk("wr_wdata", bus_wdata, 8'h5A);
    chk("wr_ack_early", ack, 4'b0000);
    tick();
    chk("wr_ack", ack, 4'b0100);
    chk("wr_strobe_off", bus_ena[2], 1'b0);
    req[2] = 1'b0;
    tick();
    chk("wr_ack_clr", ack, 4'b0000);

    // Requesters 0 and 3 read 0x11 together; pointer is 2 so round-robin serves 3 first.
`ifdef TRIBUS4_CTRL_FIXED_PRIO_EN
    first = 0; second = 3;
`else
    first = 3; second = 0;
`endif
    set_req(0, 1'b0, 7'h11, 8'h00);
    set_req(3, 1'b0, 7'h11, 8'h00);
    tick();
    chk("rd1_ena", bus_ena, {1'b0, 2'(first)});
    chk("rd1_bin", bin[first], 7'h11);
    tick();
    chk("rd1_rdata_ena", bus_ena, {1'b0, 2'(first)});
    tick();
    chk("rd1_ack", ack, 4'b0001 << first);
    chk("rd1_rdata", rdata, 8'h5A);
    req[first] = 1'b0;
    tick();
    chk("rd1_ack_clr", ack, 4'b0000);
    tick();
    chk("rd2_ena", bus_ena, {1'b0, 2'(second)});
    tick();
    tick();
    chk("rd2_ack", ack, 4'b0001 << second);
    chk("rd2_rdata", rdata, 8'h5A);
    req[second] = 1'b0;
    tick();

    // From reset, four simultaneous reads are served 0,1,2,3 four cycles apart.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) set_req(k, 1'b0, 7'h11, 8'h00);
    for (int k = 0; k < 4; k++) begin
      repeat (3) tick();
      chk($sformatf("rr_ack%0d", k), ack, 4'b0001 << k);
      chk($sformatf("rr_rdata%0d", k), rdata, 8'h5A);
      req[k] = 1'b0;
      tick();
      chk($sformatf("rr_gap%0d", k), ack, 4'b0000);
    end

    // Address wrap: top and bottom words must not alias.
    access(1, 1'b1, 7'h7F, 8'hA5, 8'h5A, "wr7f");
    access(1, 1'b1, 7'h00, 8'h3C, 8'h5A, "wr00");
    access(1, 1'b0, 7'h7F, 8'h00, 8'hA5, "rd7f");
    access(2, 1'b0, 7'h00, 8'h00, 8'h3C, "rd00");
    access(3, 1'b0, 7'h7F, 8'h00, 8'hA5, "rd7f_b3");

    // Reset during the ACCESS cycle of a write drops the strobe at once.
    set_req(0, 1'b1, 7'h22, 8'h99);
    tick();
    chk("abort_ena_pre", bus_ena, 3'b100);
    chk("abort_state_pre", dbg_state, 2'd1);
    rst = 1'b1;
    #1;
    chk("abort_ena", bus_ena, 3'b000);
    chk("abort_state", dbg_state, 2'd0);
    req[0] = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk("abort_no_ack", ack, 4'b0000);
    chk("abort_idle", dbg_state, 2'd0);
    access(0, 1'b0, 7'h22, 8'h00, 8'h00, "abort_rd22");

    // Requester drops req during ACCESS: single ack, no re-grant.
    set_req(1, 1'b0, 7'h7F, 8'h00);
    tick();
    chk("drop_state", dbg_state, 2'd1);
    req[1] = 1'b0;
    tick();
    tick();
    chk("drop_ack", ack, 4'b0010);
    chk("drop_rdata", rdata, 8'hA5);
    tick();
    chk("drop_ack_clr", ack, 4'b0000);
    tick();
    chk("drop_no_regrant", dbg_state, 2'd0);
    tick();
    chk("drop_no_ack", ack, 4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
